// File: rtl/regfile_scoreboard.sv
// Parametrised 2-read/1-write register file with a per-register busy scoreboard
// and an optional write-protected top register. Optional macro: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter bit          PROTECT_TOP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] dest_wb,
    input  logic [DATA_W-1:0] result_wb,
    output logic [DEPTH-1:0]  busy_vec
);

    localparam int unsigned    TOP_IDX  = DEPTH - 1;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(TOP_IDX);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic              wr_allow;
    logic [DEPTH-1:0]  set_mask;
    logic [DEPTH-1:0]  clr_mask;

    // Data write is dropped for the protected top register; its busy clear is not.
    always_comb begin
        wr_allow = wb_en;
        if (PROTECT_TOP && (dest_wb == TOP_ADDR)) begin
            wr_allow = 1'b0;
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_en) begin
            set_mask = DEPTH'(1) << issue_dest;
        end
        if (wb_en) begin
            clr_mask = DEPTH'(1) << dest_wb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= (i == int'(TOP_IDX)) ? '0 : DATA_W'(i);
            end
        end else if (wr_allow) begin
            regs[dest_wb] <= result_wb;
        end
    end

    // A same-edge issue wins over writeback: the newer producer is still pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign busy_vec = busy_q;

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        reg1  = regs[src1];
        reg2  = regs[src2];
        busy1 = busy_q[src1];
        busy2 = busy_q[src2];
        if (wr_allow && (dest_wb == src1)) begin
            reg1 = result_wb;
        end
        if (wr_allow && (dest_wb == src2)) begin
            reg2 = result_wb;
        end
        if (wb_en && (dest_wb == src1)) begin
            busy1 = 1'b0;
        end
        if (wb_en && (dest_wb == src2)) begin
            busy2 = 1'b0;
        end
    end
`else
    always_comb begin
        reg1  = regs[src1];
        reg2  = regs[src2];
        busy1 = busy_q[src1];
        busy2 = busy_q[src2];
    end
`endif

endmodule
